param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL take parameter DATA_W, default 16, data width in bits (1..64).
REQ-002 The block SHALL take parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W entries (256 by default).
REQ-003 The block SHALL take parameter AFULL_TH, default DEPTH-4, almost-full threshold in entries.
REQ-004 The block SHALL take parameter AEMPTY_TH, default 4, almost-empty threshold in entries.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 i_sys_clk  input  1  system clock; all state updates on the rising edge.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_din  input  DATA_W  write data.
REQ-009 i_wr_en  input  1  write request.
REQ-010 i_rd_en  input  1  read request.
REQ-011 o_dout  output  DATA_W  read data.
REQ-012 o_empty  output  1  no stored words.
REQ-013 o_full  output  1  DEPTH stored words.
REQ-014 o_almost_empty  output  1  count <= AEMPTY_TH.
REQ-015 o_almost_full  output  1  count >= AFULL_TH.
REQ-016 o_count  output  ADDR_W+1  stored word count, 0..DEPTH.
REQ-017 o_overflow  output  1  one-cycle pulse: write rejected.
REQ-018 o_underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 Write accepted iff i_wr_en=1 and o_full=0; i_din is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-020 Read accepted iff i_rd_en=1 and o_empty=0; rd_ptr increments modulo DEPTH.
REQ-021 Acceptance SHALL use the flag values before the edge: read and write on full gives read accepted and write rejected; read and write on empty gives write accepted and read rejected.
REQ-022 o_count SHALL be registered and update as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 o_empty SHALL equal (o_count==0); o_full SHALL equal (o_count==DEPTH); both are valid in the cycle after the updating edge.
REQ-024 o_almost_full and o_almost_empty SHALL be derived from o_count using unsigned compares at width ADDR_W+1.
REQ-025 A rejected write SHALL leave memory, pointers and count unchanged, and SHALL assert o_overflow for exactly the next cycle.
REQ-026 A rejected read SHALL leave o_dout, pointers and count unchanged, and SHALL assert o_underflow for exactly the next cycle.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order without loss or duplication.
REQ-028 Words SHALL be output in write order, bit-exact.

Reset
REQ-029 While i_rst=1 at a rising edge, the block SHALL clear wr_ptr, rd_ptr, o_count, o_dout, o_overflow and o_underflow to 0, set o_empty and o_almost_empty to 1, and set o_full and o_almost_full to 0.
REQ-030 Reset SHALL dominate i_wr_en and i_rd_en in the same cycle.
REQ-031 Reset applied mid-operation SHALL discard all stored words; memory contents need not be cleared.

Configuration
REQ-032 Macro FIFO_FWFT_EN SHALL select the read mode.
REQ-033 With FIFO_FWFT_EN undefined (standard mode), o_dout SHALL be registered and load mem[rd_ptr] on the edge that accepts a read, giving 1-cycle read latency; o_dout holds its value otherwise.
REQ-034 With FIFO_FWFT_EN defined (first-word fall-through), o_dout SHALL equal mem[rd_ptr] whenever o_empty=0, so the head word is valid in the same cycle o_empty falls and i_rd_en acts as a pop.
REQ-035 Count, flag, overflow and underflow behaviour SHALL be identical in both modes.

Verification
REQ-036 Defaults; assert reset, then write 256 random bytes on consecutive cycles -> o_full=1, o_count=256, o_almost_full asserted from count 252, no o_overflow.
REQ-037 Continue from full: one more write -> o_overflow pulses for 1 cycle, o_count stays 256; then 256 consecutive reads -> o_dout matches the written sequence in order, o_empty=1 at the end, o_almost_empty asserted from count 4.
REQ-038 Read while empty -> o_underflow pulses for 1 cycle, o_dout unchanged, o_count=0.
REQ-039 Hold 100 words, then assert i_wr_en and i_rd_en together for 300 cycles -> o_count stays at 100, the pointers wrap, and data order is preserved.
REQ-040 Write 0xA5 and 0x3C, then assert i_rst for 1 cycle -> o_empty=1, o_count=0, o_dout=0; the next write of 0x11 followed by a read returns 0x11.
REQ-041 FIFO_FWFT_EN defined, write 0x55 to an empty FIFO -> in the next cycle o_empty=0 and o_dout=0x55 with no read issued.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered count, full/empty/almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle-latency read.
module param_sync_fifo #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int AFULL_TH  = (2**ADDR_W) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_empty,
    output logic              o_almost_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);
    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_AFULL  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] LP_AEMPTY = (ADDR_W+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == LP_DEPTH);
    // Acceptance looks only at pre-edge flags, so a simultaneous pop never frees room for a push on full.
    assign w_wr_acc = i_wr_en & ~w_full;
    assign w_rd_acc = i_rd_en & ~w_empty;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= i_wr_en & w_full;
            r_underflow <= i_rd_en & w_empty;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_dout = w_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    assign o_dout = r_dout;
`endif

    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_empty = (r_count <= LP_AEMPTY);
    assign o_almost_full  = (r_count >= LP_AFULL);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule
